// File: rtl/alu_pkg.sv
// Shared types for the sequential logic unit: operation codes, FSM states and
// the slice-counter width rule.
package alu_pkg;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NOR} logic_op_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} lu_state_t;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational W-bit bitwise operator; no carries cross bit positions.
module logic_slice
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic_op_t    OP,
  output logic [W-1:0] Z
);

  always_comb begin
    Z = '0;
    case (OP)
      OP_AND: Z = X & Y;
      OP_OR:  Z = X | Y;
      OP_XOR: Z = X ^ Y;
      OP_NOR: Z = ~(X | Y);
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle N-bit logic unit: captures operands on the input handshake,
// evaluates one SLICE per cycle LS-first, then holds F/ZERO until accepted.
module logic_unit_seq
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int SLICE = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [1:0]   OP,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] F,
  output logic         ZERO
);

  localparam int NS = N / SLICE;
  localparam int CW = cnt_width(NS);

  generate
    if ((N % SLICE) != 0) begin : g_width_check
      $error("logic_unit_seq: N (%0d) must be a multiple of SLICE (%0d)", N, SLICE);
    end
  endgenerate

  lu_state_t      state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic_op_t      op_reg;
  logic [N-1:0]   f_reg;
  logic [N-1:0]   f_next;
  logic           zero_reg;
  logic           out_valid_reg;
  logic           in_ready_reg;

  logic [SLICE-1:0] a_slices [NS];
  logic [SLICE-1:0] b_slices [NS];
  logic [SLICE-1:0] a_sel;
  logic [SLICE-1:0] b_sel;
  logic [SLICE-1:0] z_slice;

  // Split operands into slices once so a single evaluator can be muxed on cnt.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slices
      assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
      assign f_next[gi*SLICE +: SLICE] =
        (cnt_reg == CW'(gi)) ? z_slice : f_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_sel = a_slices[cnt_reg];
  assign b_sel = b_slices[cnt_reg];

  logic_slice #(
    .W (SLICE)
  ) u_slice (
    .X  (a_sel),
    .Y  (b_sel),
    .OP (op_reg),
    .Z  (z_slice)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= OP_AND;
      f_reg         <= '0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (IN_VALID && in_ready_reg) begin
            a_reg        <= A;
            b_reg        <= B;
            op_reg       <= logic_op_t'(OP);
            cnt_reg      <= '0;
            f_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= S_RUN;
          end
        end
        S_RUN: begin
          f_reg   <= f_next;
          cnt_reg <= cnt_reg + 1'b1;
          // ZERO comes from the completed word, not the partial one.
          if (cnt_reg == CW'(NS - 1)) begin
            zero_reg      <= (f_next == '0);
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_reg;
  assign OUT_VALID = out_valid_reg;
  assign F         = f_reg;
  assign ZERO      = zero_reg;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Randomised and directed bench for logic_unit_seq against a word-level
// reference of the four bitwise operations.
module tb_logic_unit_seq;

  localparam int N      = 32;
  localparam int SLICE  = 8;
  localparam int LAT    = N / SLICE;
  localparam int PERIOD = N / SLICE + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] f;
  logic         zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(
    .N     (N),
    .SLICE (SLICE)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .A         (a),
    .B         (b),
    .OP        (op),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .F         (f),
    .ZERO      (zero)
  );

  function automatic logic [N-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic [1:0] mop);
    case (mop)
      2'd0:    return ma & mb;
      2'd1:    return ma | mb;
      2'd2:    return ma ^ mb;
      default: return ~(ma | mb);
    endcase
  endfunction

  // Drives one operation and waits for its result; returns at a negedge with
  // OUT_VALID high (or ok=0 on timeout). Operands are scrambled after capture.
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [1:0] iop,
                        input bit rdy, output logic [N-1:0] rf, output logic rz,
                        output int lat, output bit ok);
    int w;
    ok = 1'b1;
    lat = 0;
    rf = '0;
    rz = 1'b0;
    @(negedge clk);
    a = ia; b = ib; op = iop; in_valid = 1'b1; out_ready = rdy;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) ok = 1'b0;
    rf = f;
    rz = zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    a = $urandom; b = $urandom; op = 2'($urandom);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== '0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b F=%h ZERO=%b, required 1 0 0 0",
               in_ready, out_valid, f, zero);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] da [5] = '{32'd14, 32'd180, 32'd1, 32'd1543, 32'd0};
    logic [N-1:0] db [5] = '{32'd2, 32'd267, 32'd2, 32'd23, 32'd0};
    logic [1:0]   dop[5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [N-1:0] df [5] = '{32'h2, 32'h0, 32'h3, 32'h610, 32'hFFFF_FFFF};
    logic         dz [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] rf;
    logic rz;
    int lat;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      run_op(da[i], db[i], dop[i], 1'b1, rf, rz, lat, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL directed[%0d] timeout: no result within bound", i);
      end
      n_checks++;
      if (rf !== df[i] || rz !== dz[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] result: F=%h ZERO=%b, required F=%h ZERO=%b",
                 i, rf, rz, df[i], dz[i]);
      end
      n_checks++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL directed[%0d] latency: %0d cycles, required %0d", i, lat, LAT);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed[%0d] exit: out_valid=%b in_ready=%b, required 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] ia, ib, rf, exp_f;
    logic [1:0] iop;
    logic rz;
    int lat;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      ia = $urandom; ib = $urandom; iop = 2'($urandom);
      exp_f = model(ia, ib, iop);
      run_op(ia, ib, iop, 1'b0, rf, rz, lat, ok);
      n_checks++;
      if (!ok || rf !== exp_f || rz !== (exp_f == '0)) begin
        n_fail++;
        $display("FAIL backpressure[%0d] result: ok=%b F=%h ZERO=%b, required F=%h ZERO=%b",
                 k, ok, rf, rz, exp_f, (exp_f == '0));
      end
      for (int c = 0; c < 3; c++) begin
        a = $urandom; b = $urandom; op = 2'($urandom); in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (f !== rf || zero !== rz || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL backpressure[%0d] hold c%0d: F=%h ZERO=%b ov=%b ir=%b, required %h %b 1 0",
                   k, c, f, zero, out_valid, in_ready, rf, rz);
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure[%0d] release: out_valid=%b, required 0", k, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_q [$];
    logic [N-1:0] e;
    int n_hs = 0;
    int n_res = 0;
    int prev_hs = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n_res++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b unexpected result: F=%h with no outstanding operation", f);
        end else begin
          e = exp_q.pop_front();
          if (f !== e || zero !== (e == '0)) begin
            n_fail++;
            $display("FAIL b2b result: F=%h ZERO=%b, required F=%h ZERO=%b", f, zero, e, (e == '0));
          end
        end
      end
      a = $urandom; b = $urandom; op = 2'($urandom);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back(model(a, b, op));
        n_hs++;
        if (prev_hs >= 0) begin
          n_checks++;
          if (i - prev_hs !== PERIOD) begin
            n_fail++;
            $display("FAIL b2b period: %0d cycles between handshakes, required %0d", i - prev_hs, PERIOD);
          end
        end
        prev_hs = i;
      end
    end
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        n_res++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b drain unexpected result: F=%h", f);
        end else begin
          e = exp_q.pop_front();
          if (f !== e) begin
            n_fail++;
            $display("FAIL b2b drain result: F=%h, required %h", f, e);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || n_res != n_hs || n_hs < 5) begin
      n_fail++;
      $display("FAIL b2b scoreboard: %0d handshakes %0d results %0d pending, required >=5 equal 0",
               n_hs, n_res, exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] ia, ib, rf, exp_f;
    logic [1:0] iop;
    logic rz;
    int lat;
    int w;
    bit ok;
    bit seen;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    a = '0; b = '0; op = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (f !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL abort reset: F=%h out_valid=%b in_ready=%b ZERO=%b, required 0 0 1 0",
               f, out_valid, in_ready, zero);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort pulse: out_valid=1 seen for aborted operation, required none");
    end
    ia = $urandom; ib = $urandom; iop = 2'($urandom);
    exp_f = model(ia, ib, iop);
    run_op(ia, ib, iop, 1'b1, rf, rz, lat, ok);
    n_checks++;
    if (!ok || rf !== exp_f || lat !== LAT) begin
      n_fail++;
      $display("FAIL abort recovery: ok=%b F=%h lat=%0d, required F=%h lat=%0d",
               ok, rf, lat, exp_f, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] ia, ib, rf, exp_f;
    logic [1:0] iop;
    logic rz;
    int lat;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      ia = $urandom; ib = $urandom; iop = 2'($urandom);
      if (i % 4 == 3) ib = ia;
      exp_f = model(ia, ib, iop);
      run_op(ia, ib, iop, 1'b1, rf, rz, lat, ok);
      n_checks++;
      if (!ok || rf !== exp_f || rz !== (exp_f == '0) || lat !== LAT) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d A=%h B=%h: ok=%b F=%h ZERO=%b lat=%0d, required F=%h ZERO=%b lat=%0d",
                 i, iop, ia, ib, ok, rf, rz, lat, exp_f, (exp_f == '0), LAT);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
